riscv_dmem_responder: RTL and testbench

//  Data-memory responder: the slave end of the RV32I core's load/store port.

---
 rtl/riscv_dmem_responder.sv | 177 +++++++++++++++++
 tb/tb_riscv_dmem_responder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_dmem_responder.sv
// riscv_dmem_responder
//   Data-memory responder. It is the slave end of the RV32I load/store port.
//   It accepts one request at a time over a valid/ready handshake. After
//   WAIT_STATES extra busy cycles it performs the access on a word-organised
//   array. The response is then held until the requester accepts it.
//   Store data arrives right-aligned and is shifted into its byte lanes.
//   Load data is extracted from the word and sign- or zero-extended.
//   Misaligned, out-of-range and illegal-size requests get an error
//   response with no memory side effect.
//
// Ports
//   i_clk, i_rstn            clock (rising edge), asynchronous active-low reset
//   i_req_valid/o_req_ready  request handshake; ready only while idle
//   i_req_write              1 = store, 0 = load
//   i_req_addr               byte address
//   i_req_wdata              store data, right-aligned
//   i_req_byte_sel           size mask: 0001 byte, 0011 half, 1111 word
//   i_req_unsigned           load extension: 1 = zero, 0 = sign
//   o_rsp_valid/i_rsp_ready  response handshake; response held until accepted
//   o_rsp_rdata              load result; 0 for stores and errors
//   o_rsp_err                request rejected
module riscv_dmem_responder #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_STATES = 1,
  localparam int XLEN       = 32
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic            i_req_write,
  input  logic [XLEN-1:0] i_req_addr,
  input  logic [XLEN-1:0] i_req_wdata,
  input  logic [3:0]      i_req_byte_sel,
  input  logic            i_req_unsigned,
  output logic            o_rsp_valid,
  input  logic            i_rsp_ready,
  output logic [XLEN-1:0] o_rsp_rdata,
  output logic            o_rsp_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t            state_reg, state_next;
  logic [3:0]        cnt_reg, cnt_next;
  logic              capture;

  // Captured request. It is held stable from the accept edge to the access edge.
  logic              write_reg;
  logic [XLEN-1:0]   addr_reg;
  logic [XLEN-1:0]   wdata_reg;
  logic [3:0]        byte_sel_reg;
  logic              unsigned_reg;

  logic [XLEN-1:0]   rdata_reg, rdata_next;
  logic              err_reg, err_next;

  logic [XLEN-1:0]   mem [DEPTH];

  // Decode of the captured request
  logic [1:0]            offset;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic                  out_of_range;
  logic                  size_ok;
  logic                  req_err;
  logic                  access;
  logic [3:0]            lane_en;
  logic [XLEN-1:0]       wdata_sh;
  logic [XLEN-1:0]       rd_shifted;
  logic [XLEN-1:0]       load_val;

  assign offset       = addr_reg[1:0];
  assign word_idx     = addr_reg[DEPTH_LOG2+1:2];
  assign out_of_range = |addr_reg[XLEN-1:DEPTH_LOG2+2];

  always_comb begin
    size_ok = 1'b0;
    case (byte_sel_reg)
      4'b0001: size_ok = 1'b1;
      4'b0011: size_ok = ~offset[0];
      4'b1111: size_ok = (offset == 2'd0);
      default: size_ok = 1'b0;
    endcase
  end

  assign req_err = out_of_range | ~size_ok;
  assign access  = (state_reg == BUSY) && (cnt_reg == 4'd0);

  // Legal sizes never shift a lane past bit 3, so truncation to 4 bits is safe.
  assign lane_en    = byte_sel_reg << offset;
  assign wdata_sh   = wdata_reg << {offset, 3'b000};
  assign rd_shifted = mem[word_idx] >> {offset, 3'b000};

  always_comb begin
    load_val = rd_shifted;
    case (byte_sel_reg)
      4'b0001: load_val = {{24{~unsigned_reg & rd_shifted[7]}},  rd_shifted[7:0]};
      4'b0011: load_val = {{16{~unsigned_reg & rd_shifted[15]}}, rd_shifted[15:0]};
      default: load_val = rd_shifted;
    endcase
  end

  // Next-state and response logic
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    capture    = 1'b0;
    rdata_next = rdata_reg;
    err_next   = err_reg;
    case (state_reg)
      IDLE: begin
        if (i_req_valid) begin
          capture    = 1'b1;
          cnt_next   = 4'(WAIT_STATES);
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (cnt_reg != 4'd0) begin
          cnt_next = cnt_reg - 4'd1;
        end else begin
          state_next = RESP;
          err_next   = req_err;
          rdata_next = (req_err || write_reg) ? '0 : load_val;
        end
      end
      RESP: begin
        if (i_rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_reg    <= IDLE;
      cnt_reg      <= 4'd0;
      rdata_reg    <= '0;
      err_reg      <= 1'b0;
      write_reg    <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      byte_sel_reg <= 4'd0;
      unsigned_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      rdata_reg <= rdata_next;
      err_reg   <= err_next;
      if (capture) begin
        write_reg    <= i_req_write;
        addr_reg     <= i_req_addr;
        wdata_reg    <= i_req_wdata;
        byte_sel_reg <= i_req_byte_sel;
        unsigned_reg <= i_req_unsigned;
      end
    end
  end

  // The array is not reset. While i_rstn is low the FSM is forced to IDLE,
  // so access is low and a store still waiting in BUSY is dropped.
  always_ff @(posedge i_clk) begin
    if (access && write_reg && !req_err) begin
      for (int b = 0; b < 4; b++) begin
        if (lane_en[b]) mem[word_idx][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

  assign o_req_ready = (state_reg == IDLE);
  assign o_rsp_valid = (state_reg == RESP);
  assign o_rsp_rdata = rdata_reg;
  assign o_rsp_err   = err_reg;

endmodule

// File: tb/tb_riscv_dmem_responder.sv
// Testbench for riscv_dmem_responder.
// Instance 0 has WAIT_STATES=0 and instance 1 has WAIT_STATES=3.
// The expected response of each request is pushed to a queue at its
// accept edge, and popped and compared when the response appears.
module tb_riscv_dmem_responder;

  localparam int DL = 10;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn      [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_write [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_bsel  [2];
  logic        req_uns   [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  riscv_dmem_responder #(.DEPTH_LOG2(DL), .WAIT_STATES(0)) dut0 (
    .i_clk(clk), .i_rstn(rstn[0]),
    .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]),
    .i_req_write(req_write[0]), .i_req_addr(req_addr[0]),
    .i_req_wdata(req_wdata[0]), .i_req_byte_sel(req_bsel[0]),
    .i_req_unsigned(req_uns[0]),
    .o_rsp_valid(rsp_valid[0]), .i_rsp_ready(rsp_ready[0]),
    .o_rsp_rdata(rsp_rdata[0]), .o_rsp_err(rsp_err[0])
  );

  riscv_dmem_responder #(.DEPTH_LOG2(DL), .WAIT_STATES(3)) dut3 (
    .i_clk(clk), .i_rstn(rstn[1]),
    .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]),
    .i_req_write(req_write[1]), .i_req_addr(req_addr[1]),
    .i_req_wdata(req_wdata[1]), .i_req_byte_sel(req_bsel[1]),
    .i_req_unsigned(req_uns[1]),
    .o_rsp_valid(rsp_valid[1]), .i_rsp_ready(rsp_ready[1]),
    .o_rsp_rdata(rsp_rdata[1]), .o_rsp_err(rsp_err[1])
  );

  typedef struct packed {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  exp_t        sbq [$];
  logic [31:0] mdl [2][1 << DL];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model. It works byte by byte from the access size and offset.
  task automatic model_access(input int d, input bit wr, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [3:0] bs, input bit un,
                              output logic [31:0] rd, output logic er);
    int          o;
    int          idx;
    int          size;
    logic [31:0] w;
    o    = int'(addr[1:0]);
    idx  = int'((addr >> 2) & ((32'd1 << DL) - 1));
    er   = (addr >> (DL + 2)) != 0;
    size = 4;
    case (bs)
      4'b0001: size = 1;
      4'b0011: begin size = 2; if (o % 2 != 0) er = 1'b1; end
      4'b1111: begin size = 4; if (o != 0) er = 1'b1; end
      default: er = 1'b1;
    endcase
    rd = 32'h0;
    if (!er) begin
      if (wr) begin
        for (int b = 0; b < 4; b++)
          if (b >= o && b - o < size) mdl[d][idx][8*b +: 8] = wd[8*(b-o) +: 8];
      end else begin
        w = mdl[d][idx] >> (8 * o);
        if (size == 1)      rd = un ? {24'h0, w[7:0]}  : {{24{w[7]}}, w[7:0]};
        else if (size == 2) rd = un ? {16'h0, w[15:0]} : {{16{w[15]}}, w[15:0]};
        else                rd = w;
      end
    end
  endtask

  task automatic do_req(input int d, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] bs, input bit un,
                        input int hold);
    exp_t        e;
    logic [31:0] rd;
    logic        er;
    int          edges;
    int          ws;
    ws = (d == 0) ? 0 : 3;
    @(negedge clk);
    edges = 0;
    while (!req_ready[d] && edges < 50) begin @(negedge clk); edges++; end
    check("ready_before_req", {31'h0, req_ready[d]}, 32'h1);
    req_valid[d] = 1'b1; req_write[d] = wr; req_addr[d] = addr;
    req_wdata[d] = wd;   req_bsel[d]  = bs; req_uns[d]  = un;
    @(posedge clk);
    model_access(d, wr, addr, wd, bs, un, rd, er);
    sbq.push_back('{rd: rd, err: er});
    #1;
    // Scramble the request inputs. The captured copy must not change.
    req_valid[d] = 1'b0; req_write[d] = ~wr; req_addr[d] = ~addr;
    req_wdata[d] = $urandom; req_bsel[d] = 4'b0101; req_uns[d] = ~un;
    check("ready_low_busy", {31'h0, req_ready[d]}, 32'h0);
    edges = 0;
    while (!rsp_valid[d] && edges < 60) begin @(posedge clk); #1; edges++; end
    e = sbq.pop_front();
    if (!rsp_valid[d]) begin
      check("rsp_timeout", {31'h0, rsp_valid[d]}, 32'h1);
      return;
    end
    check("latency", edges, ws + 1);
    for (int h = 0; h < hold; h++) begin
      check("hold_valid", {31'h0, rsp_valid[d]}, 32'h1);
      check("hold_rdata", rsp_rdata[d], e.rd);
      check("hold_err", {31'h0, rsp_err[d]}, {31'h0, e.err});
      check("hold_req_ready", {31'h0, req_ready[d]}, 32'h0);
      @(posedge clk); #1;
    end
    check("rdata", rsp_rdata[d], e.rd);
    check("err", {31'h0, rsp_err[d]}, {31'h0, e.err});
    $display("[TB] dut%0d %s addr=0x%08h wdata=0x%08h sel=%b uns=%0d -> rdata=0x%08h err=%0d (exp 0x%08h/%0d)",
             d, wr ? "ST" : "LD", addr, wd, bs, un, rsp_rdata[d], rsp_err[d], e.rd, e.err);
    rsp_ready[d] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[d] = 1'b0;
    check("exit_valid", {31'h0, rsp_valid[d]}, 32'h0);
    check("exit_ready", {31'h0, req_ready[d]}, 32'h1);
  endtask

  task automatic check_idle_outputs(input int d, input string tag);
    check({tag, "_req_ready"}, {31'h0, req_ready[d]}, 32'h1);
    check({tag, "_rsp_valid"}, {31'h0, rsp_valid[d]}, 32'h0);
    check({tag, "_rsp_rdata"}, rsp_rdata[d], 32'h0);
    check({tag, "_rsp_err"},   {31'h0, rsp_err[d]},   32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      rstn[d] = 1'b0; req_valid[d] = 1'b0; req_write[d] = 1'b0;
      req_addr[d] = '0; req_wdata[d] = '0; req_bsel[d] = 4'b0;
      req_uns[d] = 1'b0; rsp_ready[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs(0, "rst0");
    check_idle_outputs(1, "rst1");
    @(negedge clk);
    rstn[0] = 1'b1; rstn[1] = 1'b1;

    // Word store and load
    do_req(0, 1, 32'h10, 32'hDEADBEEF, 4'b1111, 0, 0);
    do_req(0, 0, 32'h10, 32'h0,        4'b1111, 0, 0);
    // Byte store into lane 3, then loads with both extensions
    do_req(0, 1, 32'h13, 32'h00000080, 4'b0001, 0, 0);
    do_req(0, 0, 32'h13, 32'h0,        4'b0001, 0, 0);
    do_req(0, 0, 32'h13, 32'h0,        4'b0001, 1, 0);
    do_req(0, 0, 32'h10, 32'h0,        4'b1111, 1, 0);
    do_req(0, 0, 32'h11, 32'h0,        4'b0001, 1, 0);
    do_req(0, 0, 32'h11, 32'h0,        4'b0001, 0, 0);
    do_req(0, 0, 32'h12, 32'h0,        4'b0011, 0, 0);
    do_req(0, 0, 32'h10, 32'h0,        4'b0011, 1, 0);
    // Half store to the upper half. Bits above the half are ignored.
    do_req(0, 1, 32'h16, 32'hA5A5BEEF, 4'b0011, 0, 0);
    do_req(0, 0, 32'h16, 32'h0,        4'b0011, 1, 0);
    // Illegal requests
    do_req(0, 1, 32'h11, 32'h00001234, 4'b0011, 0, 0);
    do_req(0, 0, 32'h10, 32'h0,        4'b1111, 0, 0);
    do_req(0, 0, 32'h10, 32'h0,        4'b0101, 0, 0);
    do_req(0, 1, 32'h12, 32'h11112222, 4'b1111, 0, 0);
    // An out-of-range store must not alias onto word 0
    do_req(0, 1, 32'h0,  32'h01234567, 4'b1111, 0, 0);
    do_req(0, 1, 32'h1 << (DL + 2), 32'hCAFEF00D, 4'b1111, 0, 0);
    do_req(0, 0, 32'h0,  32'h0,        4'b1111, 0, 0);

    // WAIT_STATES=3: latency, and the response held while the requester stalls
    do_req(1, 1, 32'h20, 32'h55AA55AA, 4'b1111, 0, 0);
    do_req(1, 0, 32'h20, 32'h0,        4'b1111, 0, 4);
    do_req(1, 0, 32'h21, 32'h0,        4'b0001, 0, 2);

    // Reset during BUSY of a store. The store is dropped and the old data survives.
    do_req(1, 1, 32'h40, 32'h11111111, 4'b1111, 0, 0);
    do_req(1, 0, 32'h40, 32'h0,        4'b1111, 0, 0);
    @(negedge clk);
    req_valid[1] = 1'b1; req_write[1] = 1'b1; req_addr[1] = 32'h40;
    req_wdata[1] = 32'h22222222; req_bsel[1] = 4'b1111; req_uns[1] = 1'b0;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(posedge clk); #1;
    rstn[1] = 1'b0;
    #1;
    check_idle_outputs(1, "midrst");
    @(negedge clk);
    rstn[1] = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check_idle_outputs(1, "postrst");
    $display("[TB] dut1 reset asserted during BUSY of store 0x22222222 @0x00000040");
    do_req(1, 0, 32'h40, 32'h0, 4'b1111, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
